// File: rtl/fp_exc_pkg.sv
// Shared types for the floating-point exception classifier: class codes, FSM states and
// sticky flag bit positions.
package fp_exc_pkg;

  typedef enum logic [2:0] {
    ExcNormal = 3'b000,
    ExcZero   = 3'b001,
    ExcDenorm = 3'b010,
    ExcInf    = 3'b011,
    ExcQnan   = 3'b100,
    ExcSnan   = 3'b101
  } exc_class_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StGap  = 2'd2
  } exc_state_t;

  localparam int unsigned StickyW      = 5;
  localparam int unsigned StickyZero   = 0;
  localparam int unsigned StickyDenorm = 1;
  localparam int unsigned StickyInf    = 2;
  localparam int unsigned StickyQnan   = 3;
  localparam int unsigned StickySnan   = 4;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754-style operand of configurable format.
module fp_classify
  import fp_exc_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output exc_class_t           cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = op_i[MAN_W +: EXP_W];
  assign man_f       = op_i[MAN_W-1:0];
  assign unused_sign = op_i[EXP_W+MAN_W];

  always_comb begin
    cls_o = ExcNormal;
    if (exp_f == '0) begin
      cls_o = (man_f == '0) ? ExcZero : ExcDenorm;
    end else if (exp_f == {EXP_W{1'b1}}) begin
      if (man_f == '0) begin
        cls_o = ExcInf;
      end else if (man_f[MAN_W-1]) begin
        cls_o = ExcQnan;
      end else begin
        cls_o = ExcSnan;
      end
    end
  end

endmodule

// File: rtl/fp_exception_classifier.sv
// Captures NUM_CH operands per request, classifies them one cycle later and reports the
// classes with a one-cycle ACK; sticky flags accumulate per class until cleared.
module fp_exception_classifier
  import fp_exc_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_CH*(1+EXP_W+MAN_W)-1:0] Data,
  input  logic                              Data_valid,
  input  logic                              Clr_sticky,
  output logic [3*NUM_CH-1:0]               Exc,
  output logic [NUM_CH-1:0]                 Sign,
  output logic                              ACK,
  output logic                              Busy,
  output logic [StickyW-1:0]                Sticky
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  exc_state_t                state_q, state_d;
  logic [NUM_CH*W-1:0]       cap_q, cap_d;
  logic [3*NUM_CH-1:0]       exc_q, exc_d;
  logic [NUM_CH-1:0]         sign_q, sign_d;
  logic                      ack_q, ack_d;
  logic                      busy_q, busy_d;
  logic [StickyW-1:0]        sticky_q, sticky_d;

  exc_class_t                cls [NUM_CH];
  logic [3*NUM_CH-1:0]       exc_flat;
  logic [NUM_CH-1:0]         sign_cap;
  logic [StickyW-1:0]        new_flags;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fp_classify #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
    ) u_classify (
      .op_i (cap_q[g*W +: W]),
      .cls_o(cls[g])
    );
  end

  always_comb begin
    exc_flat  = '0;
    sign_cap  = '0;
    new_flags = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      exc_flat[3*i +: 3] = cls[i];
      sign_cap[i]        = cap_q[i*W + W - 1];
      unique case (cls[i])
        ExcZero:   new_flags[StickyZero]   = 1'b1;
        ExcDenorm: new_flags[StickyDenorm] = 1'b1;
        ExcInf:    new_flags[StickyInf]    = 1'b1;
        ExcQnan:   new_flags[StickyQnan]   = 1'b1;
        ExcSnan:   new_flags[StickySnan]   = 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    exc_d    = exc_q;
    sign_d   = sign_q;
    ack_d    = 1'b0;
    sticky_d = Clr_sticky ? '0 : sticky_q;
    unique case (state_q)
      StIdle: begin
        if (Data_valid) begin
          cap_d   = Data;
          state_d = StEval;
        end
      end
      StEval: begin
        exc_d    = exc_flat;
        sign_d   = sign_cap;
        ack_d    = 1'b1;
        // A clear on this edge drops old flags but keeps this request's.
        sticky_d = sticky_d | new_flags;
        state_d  = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cap_q    <= '0;
      exc_q    <= '0;
      sign_q   <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      exc_q    <= exc_d;
      sign_q   <= sign_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      sticky_q <= sticky_d;
    end
  end

  assign Exc    = exc_q;
  assign Sign   = sign_q;
  assign ACK    = ack_q;
  assign Busy   = busy_q;
  assign Sticky = sticky_q;

endmodule
